rsa_job_sequencer: RTL and testbench

Host-side job sequencer that sits directly upstream of the RSA Avalon wrapper and drives its 8-bit flag register over an Avalon-MM master. The host programs a job count through a 32-bit CSR slave and then starts the run. The block then performs one cycle per job: set flag, poll until the flag clears, count the completion. It also provides a poll-interval throttle, a timeout watchdog, abort, and an interrupt, so the host does not have to poll the RSA engine itself.

---
 rtl/rsa_seq_pkg.sv | 35 +++
 rtl/rsa_seq_if.sv | 44 ++++
 rtl/rsa_seq_csr.sv | 99 +++++++++
 rtl/rsa_job_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_rsa_job_sequencer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rsa_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rsa_seq_pkg : shared types and constants for the RSA job sequencer.   |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package rsa_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_WR  = 3'd1,
    ST_POLL_WAIT = 3'd2,
    ST_POLL_RD   = 3'd3,
    ST_STOP_WR   = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam logic [1:0] C_ADDR_CTRL      = 2'd0;
  localparam logic [1:0] C_ADDR_STATUS    = 2'd1;
  localparam logic [1:0] C_ADDR_JOB_COUNT = 2'd2;
  localparam logic [1:0] C_ADDR_JOBS_DONE = 2'd3;

  localparam int C_CTRL_START   = 0;
  localparam int C_CTRL_ABORT   = 1;
  localparam int C_CTRL_IRQ_EN  = 2;

  localparam int C_STAT_BUSY    = 0;
  localparam int C_STAT_DONE    = 1;
  localparam int C_STAT_TIMEOUT = 2;
  localparam int C_STAT_ABORTED = 3;

  localparam logic [7:0] C_FLAG_SET = 8'h01;
  localparam logic [7:0] C_FLAG_CLR = 8'h00;

endpackage
`default_nettype wire

// File: rtl/rsa_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rsa_seq_if : CSR slave bus (with irq) and flag-register master bus.   |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
interface rsa_seq_csr_if;
  logic [1:0]  avs_s0_address;
  logic        avs_s0_read;
  logic        avs_s0_write;
  logic [31:0] avs_s0_writedata;
  logic [31:0] avs_s0_readdata;
  logic        avs_s0_waitrequest;
  logic        irq;

  modport master (
    output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    input  avs_s0_readdata, avs_s0_waitrequest, irq
  );

  modport slave (
    input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    output avs_s0_readdata, avs_s0_waitrequest, irq
  );
endinterface

interface rsa_seq_avm_if;
  logic [31:0] avm_m0_address;
  logic        avm_m0_read;
  logic        avm_m0_write;
  logic [7:0]  avm_m0_writedata;
  logic [7:0]  avm_m0_readdata;
  logic        avm_m0_waitrequest;

  modport master (
    output avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_writedata,
    input  avm_m0_readdata, avm_m0_waitrequest
  );

  modport slave (
    input  avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_writedata,
    output avm_m0_readdata, avm_m0_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/rsa_seq_csr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rsa_seq_csr : CSR file, zero-latency read mux, irq and CTRL strobes.  |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module rsa_seq_csr
  import rsa_seq_pkg::*;
(
  input  wire          clk,
  input  wire          reset,
  rsa_seq_csr_if.slave s_csr,
  input  wire          i_busy,
  input  wire          i_set_done,
  input  wire          i_set_timeout,
  input  wire          i_set_aborted,
  input  wire          i_job_inc,
  output logic         o_start,
  output logic         o_abort,
  output logic [15:0]  o_job_count,
  output logic [15:0]  o_jobs_done
);

  logic        r_irq_en;
  logic        r_done;
  logic        r_timeout;
  logic        r_aborted;
  logic [15:0] r_job_count;
  logic [15:0] r_jobs_done;

  logic        w_wr_ctrl;
  logic        w_wr_stat;
  logic        w_wr_job;
  logic [31:0] w_rdata;
  logic        w_unused_wdata;

  assign w_wr_ctrl = s_csr.avs_s0_write && (s_csr.avs_s0_address == C_ADDR_CTRL);
  assign w_wr_stat = s_csr.avs_s0_write && (s_csr.avs_s0_address == C_ADDR_STATUS);
  assign w_wr_job  = s_csr.avs_s0_write && (s_csr.avs_s0_address == C_ADDR_JOB_COUNT);

  // START is only honoured when idle; ABORT only while a run is active.
  assign o_start = w_wr_ctrl && s_csr.avs_s0_writedata[C_CTRL_START] && !i_busy;
  assign o_abort = w_wr_ctrl && s_csr.avs_s0_writedata[C_CTRL_ABORT] && i_busy;

  assign o_job_count = r_job_count;
  assign o_jobs_done = r_jobs_done;

  assign w_unused_wdata = ^s_csr.avs_s0_writedata[31:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_aborted   <= 1'b0;
      r_job_count <= 16'd0;
      r_jobs_done <= 16'd0;
    end else begin
      if (w_wr_ctrl) begin
        r_irq_en <= s_csr.avs_s0_writedata[C_CTRL_IRQ_EN];
      end
      if (o_start) begin
        r_done      <= 1'b0;
        r_timeout   <= 1'b0;
        r_aborted   <= 1'b0;
        r_jobs_done <= 16'd0;
      end else begin
        // Hardware set beats a same-cycle write-1-to-clear.
        r_done    <= i_set_done    || (r_done    && !(w_wr_stat && s_csr.avs_s0_writedata[C_STAT_DONE]));
        r_timeout <= i_set_timeout || (r_timeout && !(w_wr_stat && s_csr.avs_s0_writedata[C_STAT_TIMEOUT]));
        r_aborted <= i_set_aborted || (r_aborted && !(w_wr_stat && s_csr.avs_s0_writedata[C_STAT_ABORTED]));
        if (i_job_inc && (r_jobs_done != 16'hFFFF)) begin
          r_jobs_done <= r_jobs_done + 16'd1;
        end
      end
      if (w_wr_job && !i_busy) begin
        r_job_count <= s_csr.avs_s0_writedata[15:0];
      end
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    if (s_csr.avs_s0_read) begin
      case (s_csr.avs_s0_address)
        C_ADDR_CTRL:      w_rdata[C_CTRL_IRQ_EN] = r_irq_en;
        C_ADDR_STATUS:    w_rdata[3:0] = {r_aborted, r_timeout, r_done, i_busy};
        C_ADDR_JOB_COUNT: w_rdata[15:0] = r_job_count;
        C_ADDR_JOBS_DONE: w_rdata[15:0] = r_jobs_done;
        default:          w_rdata = 32'd0;
      endcase
    end
  end

  assign s_csr.avs_s0_readdata    = w_rdata;
  assign s_csr.avs_s0_waitrequest = 1'b0;
  assign s_csr.irq                = r_irq_en && (r_done || r_timeout || r_aborted);

endmodule
`default_nettype wire

// File: rtl/rsa_job_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rsa_job_sequencer : runs N set/poll/count jobs against the RSA flag.  |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module rsa_job_sequencer
  import rsa_seq_pkg::*;
#(
  parameter logic [31:0] FLAG_ADDR      = 32'h0000_0000,
  parameter int          POLL_INTERVAL  = 64,
  parameter int          TIMEOUT_CYCLES = 1048576
) (
  input  wire           clk,
  input  wire           reset,
  rsa_seq_csr_if.slave  csr,
  rsa_seq_avm_if.master avm
);

  localparam logic [31:0] C_POLL_LAST = 32'(POLL_INTERVAL - 1);
  localparam logic [31:0] C_TIMEOUT   = 32'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic        r_read;
  logic        r_write;
  logic [7:0]  r_wdata;
  logic [31:0] r_poll_cnt;
  logic [31:0] r_wdog;
  logic        r_abort_pend;
  logic        r_set_timeout;
  logic        r_set_aborted;
  logic        r_job_inc;

  logic        w_busy;
  logic        w_start;
  logic        w_abort_req;
  logic        w_abort_any;
  logic        w_xfer_ok;
  logic        w_flag_busy;
  logic        w_wdog_exp;
  logic        w_last_job;
  logic [15:0] w_job_count;
  logic [15:0] w_jobs_done;
  logic        w_unused_rdata;

  rsa_seq_csr u_csr (
    .clk           (clk),
    .reset         (reset),
    .s_csr         (csr),
    .i_busy        (w_busy),
    .i_set_done    (r_state == ST_DONE),
    .i_set_timeout (r_set_timeout),
    .i_set_aborted (r_set_aborted),
    .i_job_inc     (r_job_inc),
    .o_start       (w_start),
    .o_abort       (w_abort_req),
    .o_job_count   (w_job_count),
    .o_jobs_done   (w_jobs_done)
  );

  assign w_busy         = (r_state != ST_IDLE);
  assign w_abort_any    = r_abort_pend || w_abort_req;
  assign w_xfer_ok      = !avm.avm_m0_waitrequest;
  assign w_flag_busy    = avm.avm_m0_readdata[0];
  assign w_wdog_exp     = (r_wdog >= C_TIMEOUT);
  assign w_last_job     = ((w_jobs_done + 16'd1) == w_job_count);
  assign w_unused_rdata = ^avm.avm_m0_readdata[7:1];

  assign avm.avm_m0_address   = FLAG_ADDR;
  assign avm.avm_m0_read      = r_read;
  assign avm.avm_m0_write     = r_write;
  assign avm.avm_m0_writedata = r_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_wdata       <= C_FLAG_CLR;
      r_poll_cnt    <= 32'd0;
      r_wdog        <= 32'd0;
      r_abort_pend  <= 1'b0;
      r_set_timeout <= 1'b0;
      r_set_aborted <= 1'b0;
      r_job_inc     <= 1'b0;
    end else begin
      r_set_timeout <= 1'b0;
      r_set_aborted <= 1'b0;
      r_job_inc     <= 1'b0;
      if (w_abort_req) begin
        r_abort_pend <= 1'b1;
      end
      if ((r_state == ST_POLL_WAIT || r_state == ST_POLL_RD) && (r_wdog != 32'hFFFF_FFFF)) begin
        r_wdog <= r_wdog + 32'd1;
      end

      case (r_state)
        ST_IDLE: begin
          r_abort_pend <= 1'b0;
          if (w_start) begin
            if (w_job_count == 16'd0) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_START_WR;
              r_write <= 1'b1;
              r_wdata <= C_FLAG_SET;
            end
          end
        end

        ST_START_WR: begin
          if (w_xfer_ok) begin
            r_wdog <= 32'd0;
            if (w_abort_any) begin
              r_state       <= ST_STOP_WR;
              r_wdata       <= C_FLAG_CLR;
              r_abort_pend  <= 1'b0;
              r_set_aborted <= 1'b1;
            end else begin
              r_state    <= ST_POLL_WAIT;
              r_write    <= 1'b0;
              r_poll_cnt <= 32'd0;
            end
          end
        end

        ST_POLL_WAIT: begin
          if (w_abort_any) begin
            r_state       <= ST_STOP_WR;
            r_write       <= 1'b1;
            r_wdata       <= C_FLAG_CLR;
            r_abort_pend  <= 1'b0;
            r_set_aborted <= 1'b1;
          end else if (w_wdog_exp) begin
            r_state       <= ST_STOP_WR;
            r_write       <= 1'b1;
            r_wdata       <= C_FLAG_CLR;
            r_set_timeout <= 1'b1;
          end else if (r_poll_cnt == C_POLL_LAST) begin
            r_state <= ST_POLL_RD;
            r_read  <= 1'b1;
          end else begin
            r_poll_cnt <= r_poll_cnt + 32'd1;
          end
        end

        ST_POLL_RD: begin
          if (w_xfer_ok) begin
            r_read <= 1'b0;
            // A completion seen on the final read is still counted even if aborting.
            if (!w_flag_busy) begin
              r_job_inc <= 1'b1;
            end
            if (w_abort_any) begin
              r_state       <= ST_STOP_WR;
              r_write       <= 1'b1;
              r_wdata       <= C_FLAG_CLR;
              r_abort_pend  <= 1'b0;
              r_set_aborted <= 1'b1;
            end else if (!w_flag_busy) begin
              if (w_last_job) begin
                r_state <= ST_DONE;
              end else begin
                r_state <= ST_START_WR;
                r_write <= 1'b1;
                r_wdata <= C_FLAG_SET;
              end
            end else if (w_wdog_exp) begin
              r_state       <= ST_STOP_WR;
              r_write       <= 1'b1;
              r_wdata       <= C_FLAG_CLR;
              r_set_timeout <= 1'b1;
            end else begin
              r_state    <= ST_POLL_WAIT;
              r_poll_cnt <= 32'd0;
            end
          end
        end

        ST_STOP_WR: begin
          if (w_xfer_ok) begin
            r_state <= ST_IDLE;
            r_write <= 1'b0;
          end
        end

        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_abort_pend <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rsa_job_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rsa_job_sequencer : directed + randomized bench with flag model.   |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_rsa_job_sequencer;
  import rsa_seq_pkg::*;

  localparam logic [31:0] TB_FLAG_ADDR = 32'h0000_0040;
  localparam int          TB_POLL      = 4;
  localparam int          TB_TIMEOUT   = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rsa_seq_csr_if csr_bus ();
  rsa_seq_avm_if avm_bus ();

  rsa_job_sequencer #(
    .FLAG_ADDR      (TB_FLAG_ADDR),
    .POLL_INTERVAL  (TB_POLL),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .csr   (csr_bus),
    .avm   (avm_bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Flag-register slave model and stall generator
  int         stall_len  = 0;
  bit         stuck      = 1'b0;
  bit         rand_delay = 1'b0;
  int         fixed_delay = 10;
  logic [7:0] flag = 8'h00;
  int         clr_cnt = 0;
  int         st = 0;

  assign avm_bus.avm_m0_readdata    = flag;
  assign avm_bus.avm_m0_waitrequest = (avm_bus.avm_m0_read || avm_bus.avm_m0_write) && (st < stall_len);

  always @(posedge clk) begin
    if (avm_bus.avm_m0_write && !avm_bus.avm_m0_waitrequest) begin
      flag    <= avm_bus.avm_m0_writedata;
      clr_cnt <= avm_bus.avm_m0_writedata[0] ? (rand_delay ? int'($urandom_range(1, 25)) : fixed_delay) : 0;
    end else if (!stuck && clr_cnt > 0) begin
      if (clr_cnt == 1) flag <= 8'h00;
      clr_cnt <= clr_cnt - 1;
    end
    if (avm_bus.avm_m0_read || avm_bus.avm_m0_write)
      st <= (st < stall_len) ? st + 1 : 0;
    else
      st <= 0;
  end

  // Bus monitor: transfer counts and stall stability
  bit          clr_mon = 1'b0;
  int          n_set = 0, n_clr = 0, n_rd = 0, n_both = 0, n_unstable = 0;
  logic        p_pend = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
  logic [7:0]  p_wd = 8'h00;
  logic [31:0] p_addr = 32'h0;

  always @(posedge clk) begin
    if (clr_mon) begin
      n_set <= 0; n_clr <= 0; n_rd <= 0; n_both <= 0; n_unstable <= 0;
    end else if (!reset) begin
      if (p_pend && (avm_bus.avm_m0_read !== p_rd || avm_bus.avm_m0_write !== p_wr ||
                     avm_bus.avm_m0_writedata !== p_wd || avm_bus.avm_m0_address !== p_addr))
        n_unstable <= n_unstable + 1;
      if (avm_bus.avm_m0_read && avm_bus.avm_m0_write) n_both <= n_both + 1;
      if (avm_bus.avm_m0_write && !avm_bus.avm_m0_waitrequest) begin
        if (avm_bus.avm_m0_writedata == C_FLAG_SET) n_set <= n_set + 1;
        else if (avm_bus.avm_m0_writedata == C_FLAG_CLR) n_clr <= n_clr + 1;
      end
      if (avm_bus.avm_m0_read && !avm_bus.avm_m0_waitrequest) n_rd <= n_rd + 1;
    end
    p_pend <= (avm_bus.avm_m0_read || avm_bus.avm_m0_write) && avm_bus.avm_m0_waitrequest && !reset;
    p_rd   <= avm_bus.avm_m0_read;
    p_wr   <= avm_bus.avm_m0_write;
    p_wd   <= avm_bus.avm_m0_writedata;
    p_addr <= avm_bus.avm_m0_address;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_bus.avs_s0_address   = a;
    csr_bus.avs_s0_writedata = d;
    csr_bus.avs_s0_write     = 1'b1;
    @(negedge clk);
    csr_bus.avs_s0_write     = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_bus.avs_s0_address = a;
    csr_bus.avs_s0_read    = 1'b1;
    #1;
    d = csr_bus.avs_s0_readdata;
    csr_bus.avs_s0_read    = 1'b0;
  endtask

  task automatic mon_clear();
    @(negedge clk);
    clr_mon = 1'b1;
    @(negedge clk);
    clr_mon = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int cyc);
    logic [31:0] s;
    s = 32'h1;
    cyc = 0;
    while (cyc < bound && s[C_STAT_BUSY]) begin
      @(negedge clk);
      cyc++;
      csr_rd(C_ADDR_STATUS, s);
    end
    check("idle_reached", {31'd0, s[C_STAT_BUSY]}, 32'd0);
  endtask

  // Expected result of a clean run of jc jobs: jc set-writes, no clear-writes.
  task automatic run_jobs(input string tag, input int jc, input int stl);
    logic [31:0] d;
    int cyc;
    stall_len = stl;
    csr_wr(C_ADDR_JOB_COUNT, 32'(jc));
    mon_clear();
    csr_wr(C_ADDR_CTRL, 32'h5);
    wait_idle(2000, cyc);
    @(negedge clk);
    csr_rd(C_ADDR_JOBS_DONE, d);
    check({tag, "_jobs_done"}, d, 32'(jc));
    csr_rd(C_ADDR_STATUS, d);
    check({tag, "_status"}, d, 32'h2);
    check({tag, "_set_writes"}, 32'(n_set), 32'(jc));
    check({tag, "_clr_writes"}, 32'(n_clr), 32'd0);
    check({tag, "_unstable"}, 32'(n_unstable), 32'd0);
    check({tag, "_rd_wr_both"}, 32'(n_both), 32'd0);
    check({tag, "_irq"}, {31'd0, csr_bus.irq}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int cyc;
    int jc;
    bit seen;

    csr_bus.avs_s0_address   = 2'd0;
    csr_bus.avs_s0_read      = 1'b0;
    csr_bus.avs_s0_write     = 1'b0;
    csr_bus.avs_s0_writedata = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      csr_rd(2'(a), d);
      check($sformatf("reset_csr%0d", a), d, 32'd0);
    end
    check("reset_read",   {31'd0, avm_bus.avm_m0_read},  32'd0);
    check("reset_write",  {31'd0, avm_bus.avm_m0_write}, 32'd0);
    check("reset_addr",   avm_bus.avm_m0_address, TB_FLAG_ADDR);
    check("reset_irq",    {31'd0, csr_bus.irq}, 32'd0);
    check("csr_waitreq",  {31'd0, csr_bus.avs_s0_waitrequest}, 32'd0);

    // Three jobs, flag clears 10 cycles after each set
    fixed_delay = 10;
    run_jobs("jobs3", 3, 0);

    // Zero jobs: straight to DONE without master traffic
    csr_wr(C_ADDR_JOB_COUNT, 32'd0);
    mon_clear();
    csr_wr(C_ADDR_CTRL, 32'h5);
    csr_rd(C_ADDR_STATUS, d);
    check("zero_status_busy", d, 32'h1);
    @(negedge clk);
    csr_rd(C_ADDR_STATUS, d);
    check("zero_status_done", d, 32'h2);
    check("zero_no_traffic", 32'(n_set + n_clr + n_rd), 32'd0);

    // Flag stuck busy: watchdog fires, one clear-write, nothing counted
    stuck = 1'b1;
    csr_wr(C_ADDR_JOB_COUNT, 32'd2);
    mon_clear();
    csr_wr(C_ADDR_CTRL, 32'h5);
    wait_idle(1000, cyc);
    check("to_elapsed_window", {31'd0, (cyc >= TB_TIMEOUT - 5) && (cyc <= TB_TIMEOUT + 15)}, 32'd1);
    csr_rd(C_ADDR_STATUS, d);
    check("to_status", d, 32'h4);
    csr_rd(C_ADDR_JOBS_DONE, d);
    check("to_jobs_done", d, 32'd0);
    check("to_set_writes", 32'(n_set), 32'd1);
    check("to_clr_writes", 32'(n_clr), 32'd1);
    check("to_irq", {31'd0, csr_bus.irq}, 32'd1);
    csr_wr(C_ADDR_STATUS, 32'h4);
    csr_rd(C_ADDR_STATUS, d);
    check("w1c_status", d, 32'h0);
    check("w1c_irq", {31'd0, csr_bus.irq}, 32'd0);
    stuck = 1'b0;

    // Five-cycle stalls on every transfer
    run_jobs("stall5", 2, 5);

    // Abort during a stalled poll read
    stuck = 1'b1;
    stall_len = 5;
    csr_wr(C_ADDR_JOB_COUNT, 32'd3);
    mon_clear();
    csr_wr(C_ADDR_CTRL, 32'h5);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = avm_bus.avm_m0_read;
    end
    check("abort_read_seen", {31'd0, seen}, 32'd1);
    csr_wr(C_ADDR_CTRL, 32'h6);
    wait_idle(1000, cyc);
    csr_rd(C_ADDR_STATUS, d);
    check("abort_status", d, 32'h8);
    check("abort_reads", 32'(n_rd), 32'd1);
    check("abort_set_writes", 32'(n_set), 32'd1);
    check("abort_clr_writes", 32'(n_clr), 32'd1);
    check("abort_unstable", 32'(n_unstable), 32'd0);
    check("abort_irq", {31'd0, csr_bus.irq}, 32'd1);
    stuck = 1'b0;
    stall_len = 0;

    // ABORT while idle has no effect
    csr_wr(C_ADDR_STATUS, 32'h8);
    csr_wr(C_ADDR_CTRL, 32'h6);
    repeat (5) @(negedge clk);
    csr_rd(C_ADDR_STATUS, d);
    check("idle_abort_status", d, 32'h0);
    check("idle_abort_clr_writes", 32'(n_clr), 32'd1);

    // Randomized job counts, stall lengths and clear delays
    rand_delay = 1'b1;
    for (int r = 0; r < 3; r++) begin
      jc = int'($urandom_range(1, 4));
      run_jobs($sformatf("rand%0d", r), jc, int'($urandom_range(0, 3)));
    end
    rand_delay = 1'b0;

    // Reset in POLL_WAIT after two completed jobs
    fixed_delay = 3;
    csr_wr(C_ADDR_JOB_COUNT, 32'd4);
    mon_clear();
    csr_wr(C_ADDR_CTRL, 32'h5);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = (n_set >= 3);
    end
    check("rst_third_job_seen", {31'd0, seen}, 32'd1);
    csr_rd(C_ADDR_JOBS_DONE, d);
    check("rst_pre_jobs_done", d, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      csr_rd(2'(a), d);
      check($sformatf("rst_csr%0d", a), d, 32'd0);
    end
    check("rst_strobes", {30'd0, avm_bus.avm_m0_read, avm_bus.avm_m0_write}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    csr_wr(C_ADDR_JOB_COUNT, 32'd2);
    mon_clear();
    csr_wr(C_ADDR_CTRL, 32'h1);
    wait_idle(2000, cyc);
    csr_rd(C_ADDR_JOBS_DONE, d);
    check("post_rst_jobs_done", d, 32'd2);
    csr_rd(C_ADDR_STATUS, d);
    check("post_rst_status", d, 32'h2);
    check("post_rst_set_writes", 32'(n_set), 32'd2);
    check("post_rst_irq_masked", {31'd0, csr_bus.irq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
